// File: rtl/inst_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_fetch : single-outstanding instruction fetch with redirect/squash and
//              immediate-format decode of the held word.       Rev 1.0
// ---------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC,
  output logic        Inst_Req_Valid,
  input  logic        Inst_Req_Ready,
  input  logic [31:0] Instruction,
  input  logic        Inst_Valid,
  output logic        Inst_Ready,
  output logic [31:0] inst_out,
  output logic [2:0]  Extype,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] inst_q, inst_d;
  logic [2:0]  extype_q, extype_d;
  logic        squash_q, squash_d;
  logic [31:0] redirect_aligned;
  logic [2:0]  extype_dec;

  assign redirect_aligned = redirect_pc & ~32'h0000_0003;

  always_comb begin
    extype_dec = 3'b000;
    case (Instruction[6:0])
      7'b0110111, 7'b0010111: extype_dec = 3'b100;
      7'b1101111:             extype_dec = 3'b011;
      7'b1100011:             extype_dec = 3'b010;
      7'b0100011:             extype_dec = 3'b001;
      default:                extype_dec = 3'b000;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    inst_d   = inst_q;
    extype_d = extype_q;
    squash_d = squash_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_valid) pc_d = redirect_aligned;
      end
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_aligned;
        end else if (Inst_Req_Ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // The outstanding response must drain before a new request can issue
        if (Inst_Valid) begin
          if (redirect_valid) begin
            pc_d     = redirect_aligned;
            squash_d = 1'b0;
            state_d  = S_REQ;
          end else if (squash_q) begin
            pc_d     = target_q;
            squash_d = 1'b0;
            state_d  = S_REQ;
          end else begin
            inst_d   = Instruction;
            extype_d = extype_dec;
            state_d  = S_HOLD;
          end
        end else if (redirect_valid) begin
          target_d = redirect_aligned;
          squash_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_aligned;
          state_d = S_REQ;
        end else if (out_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      target_q <= 32'h0000_0000;
      inst_q   <= 32'h0000_0000;
      extype_q <= 3'b000;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      inst_q   <= inst_d;
      extype_q <= extype_d;
      squash_q <= squash_d;
    end
  end

  assign PC             = pc_q;
  assign Inst_Req_Valid = (state_q == S_REQ);
  assign Inst_Ready     = (state_q == S_WAIT);
  assign out_valid      = (state_q == S_HOLD);
  assign inst_out       = inst_q;
  assign Extype         = extype_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_inst_fetch : scoreboard bench for inst_fetch.                 Rev 1.0
// ---------------------------------------------------------------------------
module tb_inst_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid = 1'b0;
  logic        Inst_Ready;
  logic [31:0] inst_out;
  logic [2:0]  Extype;
  logic        out_valid;
  logic        out_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic [31:0] w_pc, w_inst_out;
  logic        w_req_valid, w_inst_ready, w_out_valid;
  logic [2:0]  w_extype;

  inst_fetch dut (
    .clk(clk), .rst(rst), .PC(PC),
    .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
    .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
    .inst_out(inst_out), .Extype(Extype), .out_valid(out_valid), .out_ready(out_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // Second instance exercising the PC wrap from a top-of-memory reset address
  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .PC(w_pc),
    .Inst_Req_Valid(w_req_valid), .Inst_Req_Ready(1'b1),
    .Instruction(32'h0000_0013), .Inst_Valid(w_inst_ready), .Inst_Ready(w_inst_ready),
    .inst_out(w_inst_out), .Extype(w_extype), .out_valid(w_out_valid), .out_ready(1'b1),
    .redirect_valid(1'b0), .redirect_pc(32'h0000_0000)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  ext;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] mem_word  = 32'h0;
  int          mem_delay = 0;
  int          wcnt      = 0;
  assign Instruction = mem_word;

  // Memory responder: Inst_Valid rises after mem_delay cycles spent in WAIT
  always @(negedge clk) begin
    if (Inst_Ready) begin
      Inst_Valid = (wcnt >= mem_delay);
      wcnt++;
    end else begin
      Inst_Valid = 1'b0;
      wcnt = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int max, output int rdy);
    bit got;
    got = 1'b0;
    rdy = 0;
    for (int i = 0; i < max && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
      else if (Inst_Ready) rdy++;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL wait_out_valid: out_valid=0 after %0d cycles, required 1", max);
    end
  endtask

  // Monitor: pops one expectation per held word, checks stability while held
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (out_valid) begin
      chk("extype_legal", {31'b0, (Extype > 3'd4)}, 32'd0);
      if (!prev_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_valid_unexpected: inst_out=%h pc=%h, required no output", inst_out, PC);
          cur = '{pc: PC, inst: inst_out, ext: Extype};
        end else begin
          cur = q.pop_front();
          chk("held_pc", PC, cur.pc);
          chk("inst_out", inst_out, cur.inst);
          chk("extype", {29'b0, Extype}, {29'b0, cur.ext});
        end
      end else begin
        chk("inst_stable", inst_out, cur.inst);
        chk("extype_stable", {29'b0, Extype}, {29'b0, cur.ext});
      end
    end
    prev_valid = out_valid;
  end

  logic [31:0] sweep_word [7] = '{32'h0011_2023, 32'h0000_80E7, 32'h0000_2083,
                                  32'h0010_0093, 32'h0000_006F, 32'h0000_0517,
                                  32'h0020_81B3};
  logic [2:0]  sweep_ext  [7] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b011, 3'b100, 3'b000};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0; Inst_Req_Ready = 1'b1; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_pc", PC, 32'h0);
    chk("rst_req_valid", {31'b0, Inst_Req_Valid}, 32'd0);
    chk("rst_inst_ready", {31'b0, Inst_Ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_inst_out", inst_out, 32'h0);
    chk("rst_extype", {29'b0, Extype}, 32'd0);
    chk("rst_pc_w", w_pc, 32'hFFFF_FFFC);

    // lui with zero-wait memory, minimum latency
    mem_word = 32'h0000_0537; mem_delay = 0; out_ready = 1'b1;
    q.push_back('{pc: 32'h0, inst: 32'h0000_0537, ext: 3'b100});
    rst = 1'b1;
    @(negedge clk);
    chk("lat_c1_valid", {31'b0, out_valid}, 32'd0);
    chk("lat_c1_req", {31'b0, Inst_Req_Valid}, 32'd1);
    @(negedge clk);
    chk("lat_c2_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_c3_valid", {31'b0, out_valid}, 32'd1);
    chk("w_hold_pc", w_pc, 32'hFFFF_FFFC);
    chk("w_inst_out", w_inst_out, 32'h0000_0013);
    chk("w_extype", {29'b0, w_extype}, 32'd0);
    chk("w_hold_req", {31'b0, w_req_valid}, {31'b0, ~w_out_valid});
    @(negedge clk);
    chk("pc_plus4", PC, 32'h4);
    chk("w_pc_wrap", w_pc, 32'h0);

    // beq with 5-cycle memory delay and 3 stalled HOLD cycles
    mem_word = 32'hFE20_8EE3; mem_delay = 5; out_ready = 1'b0;
    q.push_back('{pc: 32'h4, inst: 32'hFE20_8EE3, ext: 3'b010});
    wait_valid(20, n);
    chk("inst_ready_cycles", n, 32'd6);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_pc", PC, 32'h4);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_next_pc", PC, 32'h8);
    chk("stall_drop_valid", {31'b0, out_valid}, 32'd0);

    // Redirect in WAIT, response 2 cycles later is squashed
    mem_word = 32'h0000_006F; mem_delay = 2;
    @(negedge clk);
    chk("sq_in_wait", {31'b0, Inst_Ready}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1003;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("sq_still_wait", {31'b0, Inst_Ready}, 32'd1);
    @(negedge clk);
    chk("sq_pc", PC, 32'h0000_1000);
    chk("sq_req", {31'b0, Inst_Req_Valid}, 32'd1);
    chk("sq_no_out", {31'b0, out_valid}, 32'd0);
    mem_word = sweep_word[0]; mem_delay = 0;
    q.push_back('{pc: 32'h1000, inst: sweep_word[0], ext: sweep_ext[0]});
    wait_valid(10, n);
    @(negedge clk);

    // Redirect coincident with Inst_Valid in WAIT
    mem_word = 32'h0000_0013;
    @(negedge clk);
    chk("co_in_wait", {31'b0, Inst_Ready}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("co_pc", PC, 32'h0000_0200);
    chk("co_no_out", {31'b0, out_valid}, 32'd0);
    chk("co_req", {31'b0, Inst_Req_Valid}, 32'd1);

    // Redirect in REQ ignores Inst_Req_Ready
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0301;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("rq_pc", PC, 32'h0000_0300);
    chk("rq_req", {31'b0, Inst_Req_Valid}, 32'd1);
    chk("rq_no_wait", {31'b0, Inst_Ready}, 32'd0);

    // Redirect in HOLD beats out_ready
    mem_word = 32'h0000_0517; out_ready = 1'b1;
    q.push_back('{pc: 32'h300, inst: 32'h0000_0517, ext: 3'b100});
    wait_valid(10, n);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("hr_pc", PC, 32'h0000_0080);
    chk("hr_valid", {31'b0, out_valid}, 32'd0);
    chk("hr_req", {31'b0, Inst_Req_Valid}, 32'd1);

    // Opcode sweep
    for (int i = 0; i < 7; i++) begin
      mem_word = sweep_word[i];
      q.push_back('{pc: 32'h80 + 32'(4 * i), inst: sweep_word[i], ext: sweep_ext[i]});
      wait_valid(10, n);
      @(negedge clk);
    end
    chk("sweep_end_pc", PC, 32'h0000_009C);

    // Reset while a response is pending
    mem_word = 32'h0000_0013; mem_delay = 100;
    repeat (2) @(negedge clk);
    chk("mr_in_wait", {31'b0, Inst_Ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_pc", PC, 32'h0);
    chk("mr_inst_ready", {31'b0, Inst_Ready}, 32'd0);
    chk("mr_inst_out", inst_out, 32'h0);
    chk("mr_extype", {29'b0, Extype}, 32'd0);
    mem_delay = 0;
    q.push_back('{pc: 32'h0, inst: 32'h0000_0013, ext: 3'b000});
    rst = 1'b1;
    wait_valid(10, n);
    @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
